stream_cipher_unit: RTL and testbench

//  Parametrised symmetric stream cipher datapath; one instance encrypts or decrypts per beat.

---
 rtl/stream_cipher_unit_if.sv | 26 ++
 rtl/stream_cipher_unit.sv | 114 +++++++++++
 tb/tb_stream_cipher_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_cipher_unit_if.sv
// rtl/stream_cipher_unit_if.sv - key-load, input-beat and output-beat bundle for stream_cipher_unit
interface stream_cipher_unit_if #(
    parameter int DW = 8,
    parameter int KW = 2
);
    logic          key_load;
    logic [KW-1:0] key_idx;
    logic [DW-1:0] key_data;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output key_load, key_idx, key_data, mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  key_load, key_idx, key_data, mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_cipher_unit.sv
// rtl/stream_cipher_unit.sv - two-stage XOR/rotate stream cipher with rotating key ring
module stream_cipher_unit #(
    parameter int                  DW         = 8,
    parameter int                  NKEYS      = 3,
    parameter int                  ROT_PERIOD = 1,
    parameter int                  PERM_ROT   = 3,
    parameter logic [NKEYS*DW-1:0] KEY_INIT   = 24'hF03C5A
) (
    input logic                  clk,
    input logic                  rst,
    stream_cipher_unit_if.slave  bus
);
    localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int CW = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;

    logic [DW-1:0]   keys [NKEYS];
    logic [KW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic            s1_valid;
    logic [DW-1:0]   s1_data;
    logic [DW-1:0]   s1_key;
    logic            s1_mode;

    logic            out_valid_r;
    logic [DW-1:0]   out_data_r;

    logic            s2_ready;
    logic            in_ready_w;
    logic            accept;
    logic [2*DW-1:0] enc_dbl;
    logic [2*DW-1:0] dec_dbl;
    logic [DW-1:0]   xf_data;

    assign s2_ready      = !out_valid_r || bus.out_ready;
    assign in_ready_w    = (!s1_valid || s2_ready) && !bus.key_load;
    assign accept        = bus.in_valid && in_ready_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    // Rotations are taken as fixed slices of the value concatenated with itself.
    always_comb begin
        enc_dbl = {2{s1_data ^ s1_key}};
        dec_dbl = {2{s1_data}};
        xf_data = '0;
        if (s1_mode) begin
            xf_data = dec_dbl[DW-1+PERM_ROT -: DW] ^ s1_key;
        end else begin
            xf_data = enc_dbl[2*DW-1-PERM_ROT -: DW];
        end
    end

    // Out-of-range key_idx matches no slot, so the write drops but the resync still happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NKEYS; i++) begin
                keys[i] <= KEY_INIT[i*DW +: DW];
            end
        end else if (bus.key_load) begin
            for (int i = 0; i < NKEYS; i++) begin
                if ((NKEYS == 1) || (bus.key_idx == KW'(i))) begin
                    keys[i] <= bus.key_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (bus.key_load) begin
            ptr <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (cnt == CW'(ROT_PERIOD - 1)) begin
                cnt <= '0;
                ptr <= (ptr == KW'(NKEYS - 1)) ? '0 : ptr + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The key travels with the beat, so later ring changes cannot touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_key   <= '0;
            s1_mode  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_key   <= keys[ptr];
            s1_mode  <= bus.mode;
        end else if (s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (s2_ready) begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                out_data_r <= xf_data;
            end
        end
    end
endmodule

// File: tb/tb_stream_cipher_unit.sv
// tb/tb_stream_cipher_unit.sv - scoreboard bench for stream_cipher_unit, ROT_PERIOD 1 and 2
module tb_stream_cipher_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_load = 1'b0;
    logic [1:0] key_idx = '0;
    logic [7:0] key_data = '0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    stream_cipher_unit_if #(.DW(8), .KW(2)) if0 ();
    stream_cipher_unit_if #(.DW(8), .KW(2)) if1 ();

    assign if0.key_load  = key_load;
    assign if0.key_idx   = key_idx;
    assign if0.key_data  = key_data;
    assign if0.mode      = mode;
    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if1.key_load  = key_load;
    assign if1.key_idx   = key_idx;
    assign if1.key_data  = key_data;
    assign if1.mode      = mode;
    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;

    stream_cipher_unit #(.DW(8), .NKEYS(3), .ROT_PERIOD(1), .PERM_ROT(3), .KEY_INIT(24'hF03C5A))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    stream_cipher_unit #(.DW(8), .NKEYS(3), .ROT_PERIOD(2), .PERM_ROT(3), .KEY_INIT(24'hF03C5A))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int         total = 0;
    int         bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic [7:0] mk0[3];
    logic [7:0] mk1[3];
    int         mp0, mc0, mp1, mc1;
    bit         rnd_rdy = 1'b0;
    bit         stall0 = 1'b0;
    bit         stall1 = 1'b0;
    logic [7:0] held0, held1;
    bit         acc;
    logic [7:0] orig[256];
    logic [7:0] encs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xf(input logic [7:0] d, input logic [7:0] k, input logic m);
        logic [7:0] r;
        if (!m) begin
            r = d ^ k;
            return {r[4:0], r[7:5]};
        end
        r = {d[2:0], d[7:3]};
        return r ^ k;
    endfunction

    task automatic model_reset();
        mk0[0] = 8'h5A; mk0[1] = 8'h3C; mk0[2] = 8'hF0;
        mk1[0] = 8'h5A; mk1[1] = 8'h3C; mk1[2] = 8'hF0;
        mp0 = 0; mc0 = 0; mp1 = 0; mc1 = 0;
    endtask

    task automatic model_accept();
        q0.push_back(xf(in_data, mk0[mp0], mode));
        q1.push_back(xf(in_data, mk1[mp1], mode));
        mc0++;
        if (mc0 == 1) begin mc0 = 0; mp0 = (mp0 + 1) % 3; end
        mc1++;
        if (mc1 == 2) begin mc1 = 0; mp1 = (mp1 + 1) % 3; end
    endtask

    task automatic model_load();
        if (key_idx < 2'd3) begin
            mk0[key_idx] = key_data;
            mk1[key_idx] = key_data;
        end
        mp0 = 0; mc0 = 0; mp1 = 0; mc1 = 0;
    endtask

    // Called at a falling edge; inputs settle, handshakes are scored, then the next falling edge.
    task automatic step();
        logic [7:0] e;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (stall0) begin
            check("hold_v0", if0.out_valid, 1);
            check("hold_d0", if0.out_data, held0);
        end
        if (stall1) begin
            check("hold_v1", if1.out_valid, 1);
            check("hold_d1", if1.out_data, held1);
        end
        if (if0.out_valid && out_ready) begin
            if (q0.size() == 0) check("extra0", q0.size(), 1);
            else begin
                e = q0.pop_front();
                check("data0", if0.out_data, e);
                got0.push_back(if0.out_data);
            end
        end
        if (if1.out_valid && out_ready) begin
            if (q1.size() == 0) check("extra1", q1.size(), 1);
            else begin
                e = q1.pop_front();
                check("data1", if1.out_data, e);
                got1.push_back(if1.out_data);
            end
        end
        stall0 = if0.out_valid && !out_ready;
        stall1 = if1.out_valid && !out_ready;
        held0 = if0.out_data;
        held1 = if1.out_data;
        if (key_load) begin
            check("ld_rdy", if0.in_ready, 0);
            model_load();
        end
        acc = in_valid && if0.in_ready;
        if (acc) model_accept();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic m);
        in_valid = 1'b1;
        in_data = d;
        mode = m;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) step();
        check("send_acc", acc, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) step();
        step();
        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);
        check("idle_v", if0.out_valid, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        key_load = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_v0", if0.out_valid, 0);
        check("rst_d0", if0.out_data, 0);
        check("rst_v1", if1.out_valid, 0);
        check("rst_d1", if1.out_data, 0);
        check("rst_rdy", if0.in_ready, 1);
        q0.delete();
        q1.delete();
        stall0 = 1'b0;
        stall1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic kload(input logic [1:0] idx, input logic [7:0] data);
        key_load = 1'b1;
        key_idx = idx;
        key_data = data;
        step();
        key_load = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n, cnt, base;
        @(negedge clk);
        do_reset();

        send(8'h00, 1'b0);
        in_valid = 1'b0;
        check("t1_lat_a", if0.out_valid, 0);
        step();
        check("t1_lat_b", if0.out_valid, 1);
        check("t1_data", if0.out_data, 8'hD2);
        drain();

        do_reset();
        for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
        drain();
        n = got0.size();
        check("t2_0", got0[n-4], 8'hD2);
        check("t2_1", got0[n-3], 8'hE1);
        check("t2_2", got0[n-2], 8'h87);
        check("t2_3", got0[n-1], 8'hD2);
        n = got1.size();
        check("t6_0", got1[n-4], 8'hD2);
        check("t6_1", got1[n-3], 8'hD2);
        check("t6_2", got1[n-2], 8'hE1);
        check("t6_3", got1[n-1], 8'hE1);

        do_reset();
        send(8'hD2, 1'b1);
        send(8'hE1, 1'b1);
        send(8'h87, 1'b1);
        drain();
        n = got0.size();
        for (int i = 0; i < 3; i++) check("t3_dec", got0[n-3+i], 8'h00);

        kload(2'd3, 8'hAA);
        base = got0.size();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            orig[i] = 8'($urandom);
            send(orig[i], 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        drain();
        encs.delete();
        for (int i = 0; i < 256; i++) encs.push_back(got0[base+i]);
        kload(2'd3, 8'h55);
        base = got0.size();
        rnd_rdy = 1'b1;
        for (int i = 0; i < 256; i++) send(encs[i], 1'b1);
        drain();
        for (int i = 0; i < 256; i++) check("t3_loop", got0[base+i], orig[i]);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h21;
        mode = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc) begin
                cnt++;
                in_data = in_data + 8'h13;
                mode = ~mode;
            end
        end
        check("t4_cnt", cnt, 2);
        check("t4_rdy", if0.in_ready, 0);
        drain();

        do_reset();
        send(8'h00, 1'b0);
        kload(2'd1, 8'h11);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        drain();
        n = got0.size();
        check("t5_0", got0[n-3], 8'hD2);
        check("t5_1", got0[n-2], 8'hD2);
        check("t5_2", got0[n-1], 8'h88);

        do_reset();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        do_reset();
        send(8'h00, 1'b0);
        drain();
        check("t6_rst0", got0[got0.size()-1], 8'hD2);
        check("t6_rst1", got1[got1.size()-1], 8'hD2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
